// File: rtl/pipe_pkg.sv
// Shared definitions for the writeback skid stage: default widths, FSM state encoding, bundle layout.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package pipe_pkg;

    localparam int DW_DEF = 128;
    localparam int AW_DEF = 5;

    // Occupancy of the two-entry skid buffer.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
    } state_t;

    // Writeback bundle at default widths; wrdata is the pre-muxed register write value.
    typedef struct packed {
        logic [DW_DEF-1:0]   dataOut;
        logic [DW_DEF/8-1:0] wbyteen;
        logic                regwren;
        logic [AW_DEF-1:0]   rwraddrd;
        logic                reginmuxop;
        logic [DW_DEF-1:0]   aluOut;
        logic [DW_DEF-1:0]   wrdata;
    } wb_bundle_t;

endpackage

// File: rtl/pipe_wb_skid_if.sv
// Handshake and writeback bus between the memory stage, the skid stage and the register file.
// Latency: n/a (wiring only).
// Backpressure: in_ready/out_ready carry it; slave is the skid stage, master is the driving side.
interface pipe_wb_skid_if
    import pipe_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) ();
    localparam int BE = DW / 8;

    logic          in_valid;
    logic          in_ready;
    logic          flush;
    logic [DW-1:0] dataOut_in;
    logic [BE-1:0] wbyteen_in;
    logic          regwren_in;
    logic [AW-1:0] rwraddrd_in;
    logic          reginmuxop_in;
    logic [DW-1:0] aluOut_in;

    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] dataOut_out;
    logic [BE-1:0] wbyteen_out;
    logic          regwren_out;
    logic [AW-1:0] rwraddrd_out;
    logic          reginmuxop_out;
    logic [DW-1:0] aluOut_out;
    logic [DW-1:0] wrdata_out;

    modport slave (
        input  in_valid, flush, dataOut_in, wbyteen_in, regwren_in, rwraddrd_in,
               reginmuxop_in, aluOut_in, out_ready,
        output in_ready, out_valid, dataOut_out, wbyteen_out, regwren_out, rwraddrd_out,
               reginmuxop_out, aluOut_out, wrdata_out
    );

    modport master (
        output in_valid, flush, dataOut_in, wbyteen_in, regwren_in, rwraddrd_in,
               reginmuxop_in, aluOut_in, out_ready,
        input  in_ready, out_valid, dataOut_out, wbyteen_out, regwren_out, rwraddrd_out,
               reginmuxop_out, aluOut_out, wrdata_out
    );

endinterface

// File: rtl/pipe_wb_entry.sv
// One storage slot of the skid buffer: enable-loaded register of a writeback bundle.
// Latency: d appears on q one clock after en.
// Backpressure: none; the owner decides when to load.
module pipe_wb_entry
    import pipe_pkg::*;
#(
    parameter type T = wb_bundle_t
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  T     d,
    output T     q
);

    // Load on enable; clear to all-zero on reset so no stale bundle leaks out.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_wb_skid.sv
// MEM/WB stage register with valid/ready handshake, 2-entry skid buffer, flush and registered wrdata mux.
// Latency: 1 cycle from acceptance to outputs; full throughput while out_ready is high.
// Backpressure: in_ready depends only on occupancy (low when both entries are full), never on out_ready.
module pipe_wb_skid
    import pipe_pkg::*;
#(
    parameter int DW = DW_DEF,  // must be a multiple of 8
    parameter int AW = AW_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    pipe_wb_skid_if.slave        bus
);
    localparam int BE = DW / 8;

    typedef struct packed {
        logic [DW-1:0] dataOut;
        logic [BE-1:0] wbyteen;
        logic          regwren;
        logic [AW-1:0] rwraddrd;
        logic          reginmuxop;
        logic [DW-1:0] aluOut;
        logic [DW-1:0] wrdata;
    } bundle_t;

    state_t  state;
    state_t  state_nxt;
    logic    out_valid_q;
    logic    regwren_q;
    logic    xfer_in;
    logic    xfer_out;
    logic    m_load;
    logic    m_from_s;
    logic    s_load;
    bundle_t in_b;
    bundle_t m_d;
    bundle_t m_q;
    bundle_t s_q;

    assign xfer_in  = bus.in_valid & bus.in_ready;
    assign xfer_out = out_valid_q & bus.out_ready;

    // Incoming bundle; wrdata is resolved here once, so later hold cycles never recompute it.
    always_comb begin
        in_b            = '0;
        in_b.dataOut    = bus.dataOut_in;
        in_b.wbyteen    = bus.wbyteen_in;
        in_b.regwren    = bus.regwren_in;
        in_b.rwraddrd   = bus.rwraddrd_in;
        in_b.reginmuxop = bus.reginmuxop_in;
        in_b.aluOut     = bus.aluOut_in;
        in_b.wrdata     = bus.reginmuxop_in ? bus.dataOut_in : bus.aluOut_in;
    end

    // Next-state and load decisions; flush overrides everything and loads nothing.
    always_comb begin
        state_nxt = state;
        m_load    = 1'b0;
        m_from_s  = 1'b0;
        s_load    = 1'b0;
        if (bus.flush) begin
            state_nxt = EMPTY;
        end else begin
            unique case (state)
                EMPTY: begin
                    if (xfer_in) begin
                        state_nxt = ONE;
                        m_load    = 1'b1;
                    end
                end
                ONE: begin
                    if (xfer_in && xfer_out) begin
                        m_load = 1'b1;
                    end else if (xfer_in) begin
                        state_nxt = TWO;
                        s_load    = 1'b1;
                    end else if (xfer_out) begin
                        state_nxt = EMPTY;
                    end
                end
                TWO: begin
                    if (xfer_out) begin
                        state_nxt = ONE;
                        m_load    = 1'b1;
                        m_from_s  = 1'b1;
                    end
                end
                default: state_nxt = EMPTY;
            endcase
        end
    end

    assign m_d = m_from_s ? s_q : in_b;

    // FSM state plus the flag outputs, registered so out_valid/regwren_out come straight from flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= EMPTY;
            out_valid_q <= 1'b0;
            regwren_q   <= 1'b0;
        end else begin
            state       <= state_nxt;
            out_valid_q <= (state_nxt != EMPTY);
            if (state_nxt == EMPTY) begin
                regwren_q <= 1'b0;
            end else if (m_load) begin
                regwren_q <= m_d.regwren;
            end else begin
                regwren_q <= m_q.regwren;
            end
        end
    end

    pipe_wb_entry #(.T(bundle_t)) u_main (
        .clk   (clk),
        .reset (reset),
        .en    (m_load),
        .d     (m_d),
        .q     (m_q)
    );

    pipe_wb_entry #(.T(bundle_t)) u_skid (
        .clk   (clk),
        .reset (reset),
        .en    (s_load),
        .d     (in_b),
        .q     (s_q)
    );

    // in_ready is the only combinational output: it must drop with reset itself.
    assign bus.in_ready       = (state != TWO) & ~reset;
    assign bus.out_valid      = out_valid_q;
    assign bus.regwren_out    = regwren_q;
    assign bus.dataOut_out    = m_q.dataOut;
    assign bus.wbyteen_out    = m_q.wbyteen;
    assign bus.rwraddrd_out   = m_q.rwraddrd;
    assign bus.reginmuxop_out = m_q.reginmuxop;
    assign bus.aluOut_out     = m_q.aluOut;
    assign bus.wrdata_out     = m_q.wrdata;

endmodule
